datapath_fsm: RTL

Instruction-sequencing controller that sits directly upstream of the 16-bit datapath. It latches one 16-bit instruction on a start request, decodes it, and walks a Moore state machine that drives every datapath control input (register read/write selects, A/B/C/status loads, operand selects, shifter, ALU op, immediate). It signals completion with `w` so the instruction source can issue the next instruction.

---
 rtl/datapath_fsm_if.sv | 27 ++
 rtl/datapath_fsm.sv | 113 +++++++++++
 2 files changed

// File: rtl/datapath_fsm_if.sv
// Instruction-source <-> sequencer bundle: start handshake plus every datapath
// control line the sequencer drives.
interface datapath_fsm_if;
  logic        s;
  logic [15:0] instr;
  logic        w;
  logic        illegal;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        loada, loadb, loadc, loads, write;
  logic        vsel, asel, bsel;
  logic [1:0]  shift;
  logic [1:0]  ALUop;
  logic [15:0] datapath_in;

  modport master (
    output s, instr,
    input  w, illegal, readnum, writenum, loada, loadb, loadc, loads, write,
           vsel, asel, bsel, shift, ALUop, datapath_in
  );

  modport slave (
    input  s, instr,
    output w, illegal, readnum, writenum, loada, loadb, loadc, loads, write,
           vsel, asel, bsel, shift, ALUop, datapath_in
  );
endinterface

// File: rtl/datapath_fsm.sv
// Moore instruction sequencer for the 16-bit datapath: latches an instruction
// in WAIT, decodes it and steps through read / execute / write-back states.
module datapath_fsm (
  input  logic          clk,
  input  logic          rst_n,
  datapath_fsm_if.slave bus
);

  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_GET_A, S_GET_B, S_EXEC, S_WR_RD, S_WR_IMM
  } state_t;

  state_t      st, nxt;
  logic [15:0] ir;

  logic [2:0] opc, rn, rd, rm;
  logic [1:0] op, sh;
  logic       is_movi, is_movr, is_alu, is_mvn, is_cmp;

  assign opc = ir[15:13];
  assign op  = ir[12:11];
  assign rn  = ir[10:8];
  assign rd  = ir[7:5];
  assign sh  = ir[4:3];
  assign rm  = ir[2:0];

  assign is_movi = (opc == 3'b110) && (op == 2'b10);
  assign is_movr = (opc == 3'b110) && (op == 2'b00);
  assign is_alu  = (opc == 3'b101);
  assign is_mvn  = is_alu && (op == 2'b11);
  assign is_cmp  = is_alu && (op == 2'b01);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= S_WAIT;
      ir <= '0;
    end else begin
      st <= nxt;
      if (st == S_WAIT && bus.s) ir <= bus.instr;
    end
  end

  assign bus.datapath_in = {{8{ir[7]}}, ir[7:0]};

  always_comb begin
    nxt          = st;
    bus.w        = 1'b0;
    bus.illegal  = 1'b0;
    bus.readnum  = rn;
    bus.writenum = rn;
    bus.loada    = 1'b0;
    bus.loadb    = 1'b0;
    bus.loadc    = 1'b0;
    bus.loads    = 1'b0;
    bus.write    = 1'b0;
    bus.vsel     = 1'b0;
    bus.asel     = 1'b0;
    bus.bsel     = 1'b0;
    bus.shift    = 2'b00;
    bus.ALUop    = 2'b00;
    case (st)
      S_WAIT: begin
        bus.w = 1'b1;
        if (bus.s) nxt = S_DECODE;
      end
      S_DECODE: begin
        if (is_movi)                 nxt = S_WR_IMM;
        else if (is_movr || is_mvn)  nxt = S_GET_B;
        else if (is_alu)             nxt = S_GET_A;
        else begin
          bus.illegal = 1'b1;
          nxt         = S_WAIT;
        end
      end
      S_GET_A: begin
        bus.readnum = rn;
        bus.loada   = 1'b1;
        nxt         = S_GET_B;
      end
      S_GET_B: begin
        bus.readnum = rm;
        bus.loadb   = 1'b1;
        nxt         = S_EXEC;
      end
      S_EXEC: begin
        // MOVR reuses the ADD path with A forced to zero: 0 + sh(Rm)
        bus.shift = sh;
        bus.asel  = is_movr || is_mvn;
        bus.ALUop = is_movr ? 2'b00 : op;
        if (is_cmp) begin
          bus.loads = 1'b1;
          nxt       = S_WAIT;
        end else begin
          bus.loadc = 1'b1;
          nxt       = S_WR_RD;
        end
      end
      S_WR_RD: begin
        bus.writenum = rd;
        bus.write    = 1'b1;
        nxt          = S_WAIT;
      end
      S_WR_IMM: begin
        bus.writenum = rn;
        bus.vsel     = 1'b1;
        bus.write    = 1'b1;
        nxt          = S_WAIT;
      end
      default: nxt = S_WAIT;
    endcase
  end

endmodule
